// File: rtl/timer.sv
// Programmable countdown timer: done rises after F x P enabled cycles (F = clk_freq, P = timer_period).
// Latency: done registered; it rises on the edge that completes the (F*P)-th enabled cycle.
// Backpressure: none; enable low pauses the count with no loss, done holds until reset.
module timer #(
  parameter int CFG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CFG_W-1:0] clk_freq,
  input  logic [CFG_W-1:0] timer_period,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CFG_W-1:0] ZERO = '0;
  localparam logic [CFG_W-1:0] ONE  = CFG_W'(1);

  state_t           state_q, state_d;
  logic [CFG_W-1:0] f_q, f_d;
  logic [CFG_W-1:0] p_q, p_d;
  logic [CFG_W-1:0] presc_q, presc_d;
  logic [CFG_W-1:0] sec_q, sec_d;
  logic             done_q, done_d;

  // Zero configuration values behave as one.
  logic [CFG_W-1:0] f_eff, p_eff;
  // Operands of the one-cycle advance; in IDLE they come from the live inputs
  // and a cleared count, so the starting edge is counted as cycle 1.
  logic [CFG_W-1:0] base_f, base_p, base_presc, base_sec;
  logic [CFG_W-1:0] nxt_presc, nxt_sec;
  logic             sec_wrap, finish;

  // Advance the prescaler/second counter by one enabled cycle.
  always_comb begin
    f_eff      = (clk_freq == ZERO) ? ONE : clk_freq;
    p_eff      = (timer_period == ZERO) ? ONE : timer_period;
    base_f     = (state_q == IDLE) ? f_eff : f_q;
    base_p     = (state_q == IDLE) ? p_eff : p_q;
    base_presc = (state_q == IDLE) ? ZERO : presc_q;
    base_sec   = (state_q == IDLE) ? ZERO : sec_q;
    sec_wrap   = (base_presc == (base_f - ONE));
    nxt_presc  = sec_wrap ? ZERO : (base_presc + ONE);
    nxt_sec    = sec_wrap ? (base_sec + ONE) : base_sec;
    finish     = sec_wrap && (nxt_sec == base_p);
  end

  // Next-state logic: start on enable, count while enabled, park in DONE.
  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    p_d     = p_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          f_d     = f_eff;
          p_d     = p_eff;
          presc_d = nxt_presc;
          sec_d   = nxt_sec;
          state_d = finish ? DONE : COUNT;
          done_d  = finish;
        end
      end
      COUNT: begin
        if (enable) begin
          presc_d = nxt_presc;
          sec_d   = nxt_sec;
          if (finish) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      f_q     <= '0;
      p_q     <= '0;
      presc_q <= '0;
      sec_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      p_q     <= p_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_timer.sv
// Directed and random runs of the countdown timer against a scoreboard of expected done edges.
// Latency: each expectation is the enabled-edge count at which done must rise.
// Backpressure: none; the stimulus waits for the scoreboard to drain after each run.
module tb_timer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] clk_freq;
  logic [3:0] timer_period;
  logic       done;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;      // enabled, non-reset edges since the last reset edge
  logic last_rst = 1'b0;
  logic done_prev = 1'b0;
  int sb[$];

  timer #(.CFG_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clk_freq     (clk_freq),
    .timer_period (timer_period),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge with the given enable/reset; bookkeeping is done 1 unit after the edge.
  task automatic cyc(input logic en, input logic rs);
    enable = en;
    reset  = rs;
    @(posedge clk);
    #1;
    last_rst = rs;
    if (rs) en_cnt = 0;
    else if (en) en_cnt++;
  endtask

  // Reset, program F/P, expect done at enabled edge exp; optional enable gap and config change.
  task automatic run(input int f, input int p, input int exp, input int gap_at,
                     input int gap_len, input int new_f, input logic en_with_rst);
    int n;
    int g;
    clk_freq     = 4'(f);
    timer_period = 4'(p);
    cyc(en_with_rst, 1'b1);
    sb.push_back(exp);
    n = 0;
    g = 0;
    while (en_cnt < exp + 3 && n < exp + gap_len + 20) begin
      if (new_f >= 0 && en_cnt == 2) clk_freq = 4'(new_f);
      if (en_cnt == gap_at && g < gap_len) begin
        g++;
        cyc(1'b0, 1'b0);
      end else begin
        cyc(1'b1, 1'b0);
      end
      n++;
    end
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL done_timeout F=%0d P=%0d: done not seen by enabled edge %0d, required at %0d",
               f, p, en_cnt, sb[0]);
      sb.delete();
    end
  endtask

  // Monitor: compares every done rise against the scoreboard, checks hold and reset clear.
  always @(posedge clk) begin
    #2;
    if (last_rst) begin
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL reset_done: done=%b required 0", done);
      end
    end else if (done === 1'b1 && done_prev === 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: rose at enabled edge %0d with no expectation", en_cnt);
      end else begin
        int exp;
        exp = sb.pop_front();
        if (en_cnt != exp) begin
          errors++;
          $display("FAIL done_edge: rose at enabled edge %0d required %0d", en_cnt, exp);
        end
      end
    end else if (done !== 1'b1 && done_prev === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_hold: done=%b fell without reset, required 1", done);
    end
    done_prev = done;
  end

  initial begin
    int f;
    int p;
    reset        = 1'b1;
    enable       = 1'b0;
    clk_freq     = 4'd0;
    timer_period = 4'd0;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);

    // F=5 P=1, enable held high
    run(5, 1, 5, -1, 0, -1, 1'b0);
    // F=3 P=4 with a 6-cycle pause after enabled edge 5
    run(3, 4, 12, 5, 6, -1, 1'b0);
    // full-scale count and the minimum count
    run(15, 15, 225, -1, 0, -1, 1'b0);
    run(1, 1, 1, -1, 0, -1, 1'b0);
    // mid-count reset after 7 enabled edges: no done expected from this partial run
    clk_freq     = 4'd4;
    timer_period = 4'd4;
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
    // fresh run takes the full 16 edges even though clk_freq changes to 1 mid-count
    run(4, 4, 16, -1, 0, 1, 1'b0);
    // zero configuration treated as one
    run(0, 3, 3, -1, 0, -1, 1'b0);
    run(2, 0, 2, -1, 0, -1, 1'b0);
    run(0, 0, 1, -1, 0, -1, 1'b0);
    // enable alongside reset records no progress
    run(0, 3, 3, -1, 0, -1, 1'b1);
    // single-cycle start pulse followed by a pause keeps its progress
    run(2, 2, 4, 1, 3, -1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      f = int'($urandom_range(1, 15));
      p = int'($urandom_range(1, 15));
      run(f, p, f * p, int'($urandom_range(0, 10)), int'($urandom_range(0, 4)), -1, 1'b0);
    end

    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
